// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller -- multicycle MIPS-style main control unit.
//
// Moore FSM that sequences fetch, decode and the execute/memory/writeback
// steps of lw, sw, R-type, beq, addi and j. The control word is registered
// alongside the state: on each edge the block loads the control word that
// belongs to the state being entered, so every output comes straight from a
// flop. The only exception is PCEn, which also combines the live Zero flag.
//
// Optional feature (define macro MC_BNE_EN):
//   Adds bne (Op 000101). It shares the BEQEX state, but raises BranchNe
//   instead of Branch. With the macro undefined, bne is an illegal opcode
//   and executes as a two-cycle NOP.
//
// Ports:
//   clk         in   system clock, rising-edge active
//   reset       in   asynchronous active-high reset, forces FETCH
//   Op[5:0]     in   opcode, IR[31:26]
//   Funct[5:0]  in   R-type function field, IR[5:0]
//   Zero        in   ALU zero flag
//   ALUControl  out  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   ALUSrcA     out  0 = PC, 1 = register A
//   ALUSrcB     out  00 B, 01 const 4, 10 sign-ext imm, 11 imm << 2
//   IorD        out  memory address: 0 = PC, 1 = ALUOut
//   MemWrite    out  memory write strobe
//   IRWrite     out  instruction register write strobe
//   RegWrite    out  register file write strobe
//   RegDst      out  write-register select (1 = rd)
//   MemtoReg    out  write-data select (1 = memory data)
//   PCSrc[1:0]  out  00 ALU result, 01 ALUOut, 10 jump target
//   PCEn        out  PC load enable
//   State[3:0]  out  current state code (debug)
// ---------------------------------------------------------------------------
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic [2:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       memto_reg;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    state_t state;
    state_t next_state;
    ctrl_t  ctrl;

    // R-type function field to ALU operation; unknown functions default to ADD.
    function automatic logic [2:0] funct_decode(input logic [5:0] funct);
        case (funct)
            6'b100000: return 3'b010;  // add
            6'b100010: return 3'b110;  // sub
            6'b100100: return 3'b000;  // and
            6'b100101: return 3'b001;  // or
            6'b101010: return 3'b111;  // slt
            default:   return 3'b010;
        endcase
    endfunction

    function automatic state_t next_state_f(input state_t s, input logic [5:0] op);
        case (s)
            FETCH:  return DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: return MEMADR;
                    OP_RTYPE:     return RTYPEEX;
                    OP_BEQ:       return BEQEX;
`ifdef MC_BNE_EN
                    OP_BNE:       return BEQEX;
`endif
                    OP_ADDI:      return ADDIEX;
                    OP_J:         return JEX;
                    default:      return FETCH;  // illegal opcode runs as a NOP
                endcase
            end
            MEMADR:  return (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   return MEMWB;
            RTYPEEX: return RTYPEWB;
            ADDIEX:  return ADDIWB;
            default: return FETCH;  // terminal states and unused codes 12-15
        endcase
    endfunction

    // Control word asserted while the FSM sits in state s.
    function automatic ctrl_t ctrl_f(input state_t s, input logic [5:0] funct);
        ctrl_t c;
        c             = '0;
        c.alu_control = 3'b010;
        case (s)
            FETCH: begin
                c.alu_src_b = 2'b01;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
            end
            DECODE:  c.alu_src_b = 2'b11;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWB: begin
                c.memto_reg = 1'b1;
                c.reg_write = 1'b1;
            end
            MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            RTYPEEX: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = funct_decode(funct);
            end
            RTYPEWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            BEQEX: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = 3'b110;
                c.pc_src      = 2'b01;
                c.branch      = 1'b1;
            end
            ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ADDIWB:  c.reg_write = 1'b1;
            JEX: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        next_state = FETCH;
        next_state = next_state_f(state, Op);
    end

`ifdef MC_BNE_EN
    logic branch_ne;
`endif

    // State and control word are loaded together, so the control word always
    // matches the state register, including during and right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state <= FETCH;
            ctrl  <= ctrl_f(FETCH, 6'd0);
`ifdef MC_BNE_EN
            branch_ne <= 1'b0;
`endif
        end else begin
            state <= next_state;
            ctrl  <= ctrl_f(next_state, Funct);
`ifdef MC_BNE_EN
            // bne reuses BEQEX but swaps Branch for BranchNe.
            if (next_state == BEQEX && Op == OP_BNE) begin
                ctrl.branch <= 1'b0;
                branch_ne   <= 1'b1;
            end else begin
                branch_ne   <= 1'b0;
            end
`endif
        end
    end

    assign ALUControl = ctrl.alu_control;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign IorD       = ctrl.iord;
    assign MemWrite   = ctrl.mem_write;
    assign IRWrite    = ctrl.ir_write;
    assign RegWrite   = ctrl.reg_write;
    assign RegDst     = ctrl.reg_dst;
    assign MemtoReg   = ctrl.memto_reg;
    assign PCSrc      = ctrl.pc_src;
    assign State      = state;

`ifdef MC_BNE_EN
    assign PCEn = ctrl.pc_write | (ctrl.branch & Zero) | (branch_ne & ~Zero);
`else
    assign PCEn = ctrl.pc_write | (ctrl.branch & Zero);
`endif

endmodule

// File: tb/tb_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_mc_controller -- directed self-checking bench for mc_controller.
// Walks each instruction class through its state sequence, checks the
// per-state control outputs, the Zero-dependent PCEn in BEQEX, and an
// asynchronous reset pulse in the middle of an instruction. bne behaviour
// follows the MC_BNE_EN macro used for the build.
// ---------------------------------------------------------------------------
module tb_mc_controller;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Op    = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       Zero  = 1'b0;
    logic [2:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic [3:0] State;

    int total  = 0;
    int passed = 0;

    mc_controller dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .Zero      (Zero),
        .ALUControl(ALUControl),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .IorD      (IorD),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .PCSrc     (PCSrc),
        .PCEn      (PCEn),
        .State     (State)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [3:0] exp_state);
        tick();
        check(tag, {28'd0, State}, {28'd0, exp_state});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    logic [2:0] ac_tab [6] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};

    initial begin
        // Reset state: FETCH values while reset is held.
        Op = 6'b100011;
        reset = 1'b1;
        repeat (2) tick();
        check("rst_state",   {28'd0, State},      32'd0);
        check("rst_irwrite", {31'd0, IRWrite},    32'd1);
        check("rst_pcen",    {31'd0, PCEn},       32'd1);
        check("rst_alusrcb", {30'd0, ALUSrcB},    32'd1);
        check("rst_aluctl",  {29'd0, ALUControl}, 32'd2);
        check("rst_memwr",   {31'd0, MemWrite},   32'd0);
        reset = 1'b0;

        // lw: 0,1,2,3,4,0
        step("lw_decode", 4'd1);
        check("decode_alusrcb", {30'd0, ALUSrcB}, 32'd3);
        check("decode_irwrite", {31'd0, IRWrite}, 32'd0);
        check("decode_pcen",    {31'd0, PCEn},    32'd0);
        step("lw_memadr", 4'd2);
        check("memadr_srca", {31'd0, ALUSrcA}, 32'd1);
        check("memadr_srcb", {30'd0, ALUSrcB}, 32'd2);
        step("lw_memrd", 4'd3);
        check("memrd_iord", {31'd0, IorD}, 32'd1);
        step("lw_memwb", 4'd4);
        check("memwb_regwrite", {31'd0, RegWrite}, 32'd1);
        check("memwb_memtoreg", {31'd0, MemtoReg}, 32'd1);
        step("lw_back_fetch", 4'd0);

        // Async reset pulse mid-MEMRD, no clock edge in between.
        step("lw2_decode", 4'd1);
        step("lw2_memadr", 4'd2);
        step("lw2_memrd", 4'd3);
        reset = 1'b1;
        #1;
        check("async_rst_state",   {28'd0, State},    32'd0);
        check("async_rst_irwrite", {31'd0, IRWrite},  32'd1);
        check("async_rst_memwr",   {31'd0, MemWrite}, 32'd0);
        check("async_rst_regwr",   {31'd0, RegWrite}, 32'd0);
        #1;
        reset = 1'b0;
        step("post_rst_decode", 4'd1);
        step("post_rst_memadr", 4'd2);
        step("post_rst_memrd", 4'd3);
        step("post_rst_memwb", 4'd4);
        step("post_rst_fetch", 4'd0);

        // sw: 0,1,2,5,0
        Op = 6'b101011;
        step("sw_decode", 4'd1);
        step("sw_memadr", 4'd2);
        step("sw_memwr", 4'd5);
        check("memwr_memwrite", {31'd0, MemWrite}, 32'd1);
        check("memwr_iord",     {31'd0, IorD},     32'd1);
        check("memwr_regwrite", {31'd0, RegWrite}, 32'd0);
        step("sw_fetch", 4'd0);

        // R-type: ALU control for every listed funct plus one unknown value.
        Op = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            Funct = fn_tab[i];
            step($sformatf("rt%0d_decode", i), 4'd1);
            step($sformatf("rt%0d_ex", i), 4'd6);
            check($sformatf("rt%0d_aluctl", i), {29'd0, ALUControl}, {29'd0, ac_tab[i]});
            check($sformatf("rt%0d_srca", i),   {31'd0, ALUSrcA},    32'd1);
            check($sformatf("rt%0d_srcb", i),   {30'd0, ALUSrcB},    32'd0);
            step($sformatf("rt%0d_wb", i), 4'd7);
            check($sformatf("rt%0d_regdst", i),   {31'd0, RegDst},   32'd1);
            check($sformatf("rt%0d_regwrite", i), {31'd0, RegWrite}, 32'd1);
            step($sformatf("rt%0d_fetch", i), 4'd0);
        end

        // beq: PCEn follows Zero combinationally inside BEQEX.
        Op = 6'b000100;
        Zero = 1'b0;
        step("beq_decode", 4'd1);
        step("beq_ex", 4'd8);
        Zero = 1'b1;
        #1;
        check("beq_z1_pcen",   {31'd0, PCEn},       32'd1);
        check("beq_z1_pcsrc",  {30'd0, PCSrc},      32'd1);
        check("beq_z1_aluctl", {29'd0, ALUControl}, 32'd6);
        Zero = 1'b0;
        #1;
        check("beq_z0_pcen",   {31'd0, PCEn},       32'd0);
        check("beq_z0_aluctl", {29'd0, ALUControl}, 32'd6);
        step("beq_fetch", 4'd0);

        // addi: 0,1,9,10,0
        Op = 6'b001000;
        step("addi_decode", 4'd1);
        step("addi_ex", 4'd9);
        check("addiex_srca", {31'd0, ALUSrcA}, 32'd1);
        check("addiex_srcb", {30'd0, ALUSrcB}, 32'd2);
        step("addi_wb", 4'd10);
        check("addiwb_regwrite", {31'd0, RegWrite}, 32'd1);
        check("addiwb_regdst",   {31'd0, RegDst},   32'd0);
        step("addi_fetch", 4'd0);

        // j: 0,1,11,0
        Op = 6'b000010;
        step("j_decode", 4'd1);
        step("j_ex", 4'd11);
        check("jex_pcsrc", {30'd0, PCSrc}, 32'd2);
        check("jex_pcen",  {31'd0, PCEn},  32'd1);
        step("j_fetch", 4'd0);

        // bne
        Op = 6'b000101;
        Zero = 1'b1;
        step("bne_decode", 4'd1);
`ifdef MC_BNE_EN
        step("bne_ex", 4'd8);
        Zero = 1'b0;
        #1;
        check("bne_z0_pcen",  {31'd0, PCEn},  32'd1);
        check("bne_z0_pcsrc", {30'd0, PCSrc}, 32'd1);
        Zero = 1'b1;
        #1;
        check("bne_z1_pcen", {31'd0, PCEn}, 32'd0);
        step("bne_fetch", 4'd0);
`else
        check("bne_nop_strobes", {28'd0, MemWrite, RegWrite, IRWrite, PCEn}, 32'd0);
        step("bne_nop_fetch", 4'd0);
`endif

        // Illegal opcode: two-cycle NOP.
        Op = 6'b111111;
        Zero = 1'b1;
        step("ill_decode", 4'd1);
        check("ill_strobes", {28'd0, MemWrite, RegWrite, IRWrite, PCEn}, 32'd0);
        step("ill_fetch", 4'd0);
        check("ill_fetch_irwrite", {31'd0, IRWrite}, 32'd1);

        // Synchronous-style reset from a mid-instruction state.
        Op = 6'b001000;
        step("addi2_decode", 4'd1);
        step("addi2_ex", 4'd9);
        do_reset();
        check("rst_from_addiex", {28'd0, State}, 32'd0);
        step("rst_then_decode", 4'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
